// File: rtl/if_fetch_unit.sv
// Fetch stage feeding the IF/ID register: owns the PC, runs the imem request/ready
// handshake, and absorbs misses, stalls, branch redirects (also mid-miss) and HLT.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] opcOut,
  output logic [15:0] pcOut,
  output logic [15:0] instrOut,
  output logic        validOut,
  output logic        ifid_en,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pending_pc;
  logic [15:0]  pc_next_seq;
  logic         is_hlt;

  assign pc_next_seq = pc + 16'd2;
  assign is_hlt      = (imem_rdata[15:12] == 4'hF);
  assign imem_addr   = pc;

  // DRAIN waits out a miss whose address was abandoned by a redirect; the request
  // stays up so the memory handshake is never dropped mid-transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= RESET_PC;
      pending_pc <= 16'h0000;
      state      <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            if (redirect) begin
              if (imem_ready) begin
                pc <= redirect_pc;
              end else begin
                pending_pc <= redirect_pc;
                state      <= DRAIN;
              end
            end else if (imem_ready) begin
              if (is_hlt) state <= HALT;
              else        pc    <= pc_next_seq;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (redirect) pending_pc <= redirect_pc;
            if (imem_ready) begin
              pc    <= redirect ? redirect_pc : pending_pc;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ifid_en  = 1'b0;
    validOut = 1'b0;
    halted   = 1'b0;
    instrOut = BUBBLE_INSTR;
    opcOut   = pc;
    pcOut    = pc_next_seq;
    if (rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ifid_en  = ~stall;
          if (!stall && !redirect && imem_ready) begin
            validOut = 1'b1;
            instrOut = imem_rdata;
          end
        end
        DRAIN: begin
          imem_req = 1'b1;
          ifid_en  = ~stall;
        end
        HALT: begin
          ifid_en = ~stall;
          halted  = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural fetch model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] opcOut;
  logic [15:0] pcOut;
  logic [15:0] instrOut;
  logic        validOut;
  logic        ifid_en;
  logic        halted;

  int vectorCount = 0;
  int missCount   = 0;

  // Model: where fetch is, whether a redirect target is waiting on a dead miss,
  // and whether HLT has been delivered.
  logic [15:0] modelPc;
  logic        modelWaiting;
  logic [15:0] modelTarget;
  logic        modelHalted;

  if_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .opcOut(opcOut),
    .pcOut(pcOut),
    .instrOut(instrOut),
    .validOut(validOut),
    .ifid_en(ifid_en),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic compareModel();
    logic expValid;
    expValid = rst && !modelHalted && !modelWaiting && !stall && !redirect && imem_ready;
    checkOutput("imem_req",  {15'd0, imem_req}, {15'd0, rst && !modelHalted});
    checkOutput("imem_addr", imem_addr, modelPc);
    checkOutput("ifid_en",   {15'd0, ifid_en}, {15'd0, rst && !stall});
    checkOutput("validOut",  {15'd0, validOut}, {15'd0, expValid});
    checkOutput("instrOut",  instrOut, expValid ? imem_rdata : 16'h0000);
    checkOutput("opcOut",    opcOut, modelPc);
    checkOutput("pcOut",     pcOut, modelPc + 16'd2);
    checkOutput("halted",    {15'd0, halted}, {15'd0, rst && modelHalted});
  endtask

  task automatic updateModel();
    if (!rst) begin
      modelPc      = 16'h0000;
      modelWaiting = 1'b0;
      modelTarget  = 16'h0000;
      modelHalted  = 1'b0;
    end else if (modelHalted || stall) begin
      // nothing moves
    end else if (modelWaiting) begin
      if (redirect) modelTarget = redirect_pc;
      if (imem_ready) begin
        modelPc      = modelTarget;
        modelWaiting = 1'b0;
      end
    end else if (redirect) begin
      if (imem_ready) modelPc = redirect_pc;
      else begin
        modelWaiting = 1'b1;
        modelTarget  = redirect_pc;
      end
    end else if (imem_ready) begin
      if (imem_rdata[15:12] == 4'hF) modelHalted = 1'b1;
      else                           modelPc     = modelPc + 16'd2;
    end
  endtask

  // One cycle: drive just after an edge, compare mid-cycle, advance model at the edge.
  task automatic applyStimulus(input logic rs, input logic st, input logic rd,
                               input logic [15:0] rpc, input logic rdy, input logic [15:0] data);
    rst         = rs;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = data;
    #2;
    compareModel();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b0; imem_rdata = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelPc = 16'h0000; modelWaiting = 1'b0; modelTarget = 16'h0000; modelHalted = 1'b0;

    applyStimulus(0, 0, 0, 16'h0, 1, 16'h1123);
    // Streaming hits at 0 and 2
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h1123);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h1123);
    checkOutput("addr_after_two_hits", imem_addr, 16'h0004);
    // Three-cycle miss at 4, then delivery
    repeat (3) applyStimulus(1, 0, 0, 16'h0, 0, 16'hDEAD);
    checkOutput("addr_held_miss", imem_addr, 16'h0004);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h2222);
    checkOutput("addr_after_miss", imem_addr, 16'h0006);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h3333);
    // Redirect on a hit at 8
    applyStimulus(1, 0, 1, 16'h0040, 1, 16'h4444);
    checkOutput("redirect_hit_addr", imem_addr, 16'h0040);
    // Miss at 0x40, redirect in the miss, ready two cycles later
    applyStimulus(1, 0, 0, 16'h0, 0, 16'h5555);
    applyStimulus(1, 0, 1, 16'h0100, 0, 16'h5555);
    applyStimulus(1, 0, 0, 16'h0, 0, 16'h5555);
    checkOutput("drain_addr_held", imem_addr, 16'h0040);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h5555);
    checkOutput("redirect_miss_addr", imem_addr, 16'h0100);
    // Stall with ready and an ignored redirect
    repeat (2) applyStimulus(1, 1, 1, 16'h0200, 1, 16'h6666);
    checkOutput("stall_pc_held", imem_addr, 16'h0100);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h7777;
    #2;
    checkOutput("post_stall_opc", opcOut, 16'h0100);
    checkOutput("post_stall_valid", {15'd0, validOut}, 16'h0001);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h7777);
    // Wrap from 0xFFFE
    applyStimulus(1, 0, 1, 16'hFFFE, 1, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h1234);
    checkOutput("wrap_addr", imem_addr, 16'h0000);
    // HLT then halted behaviour
    applyStimulus(1, 0, 0, 16'h0, 1, 16'hF000);
    checkOutput("halted_rise", {15'd0, halted}, 16'h0001);
    applyStimulus(1, 0, 1, 16'h0300, 1, 16'h1111);
    applyStimulus(1, 1, 0, 16'h0, 1, 16'h1111);
    checkOutput("halt_addr", imem_addr, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h1111);
    checkOutput("restart_addr", imem_addr, 16'h0000);
    checkOutput("restart_halted", {15'd0, halted}, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rs, st, rd, rdy;
      logic [15:0] rpc, data;
      rs   = ($urandom_range(0, 99) >= 2) && !(modelHalted && $urandom_range(0, 9) == 0);
      st   = ($urandom_range(0, 9) < 2);
      rd   = ($urandom_range(0, 9) < 2);
      rdy  = ($urandom_range(0, 9) < 6);
      rpc  = 16'($urandom) & 16'hFFFE;
      data = 16'($urandom);
      if (data[15:12] == 4'hF && $urandom_range(0, 3) != 0) data[15] = 1'b0;
      applyStimulus(rs, st, rd, rpc, rdy, data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
